// File: rtl/hdmiin_align_ctrl.sv
// HDMI input alignment controller: sweeps IDELAY taps per word shift and locks at the centre of the first widest token eye.
// Optional macro HDMIIN_ALIGN_TRACK_EN keeps monitoring tokens while locked and recalibrates after two empty windows.
`timescale 1ns/1ps

module hdmiin_align_ctrl #(
  parameter int LGDWELL    = 12,
  parameter int MIN_TOKENS = 8,
  parameter int MIN_EYE    = 4,
  parameter int LGSETTLE   = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_restart,
  input  logic [9:0] i_word,
  output logic [4:0] o_delay,
  output logic [3:0] o_shift,
  output logic [9:0] o_word,
  output logic       o_locked
);

  typedef enum logic [2:0] {SETTLE, MEASURE, EVAL, APPLY, LOCKED} state_t;

  localparam int CNT_W = (LGDWELL > LGSETTLE) ? LGDWELL : LGSETTLE;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((1 << LGSETTLE) - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'((1 << LGDWELL) - 1);
  localparam int TOK_W = $clog2(MIN_TOKENS + 1);
  localparam logic [TOK_W-1:0] TOK_MIN = TOK_W'(MIN_TOKENS);
  localparam logic [5:0] EYE_MIN = 6'(MIN_EYE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOK_W-1:0] tok_q, tok_d, tok_next;
  logic [4:0]       delay_d, run_start_q, run_start_d, best_start_q, best_start_d;
  logic [5:0]       run_len_q, run_len_d, best_len_q, best_len_d;
  logic [3:0]       shift_d;
  logic             locked_d, restart, is_token, pass;
  logic [9:0]       prev_word;
  logic [24:0]      concat;
`ifdef HDMIIN_ALIGN_TRACK_EN
  logic             miss_q, miss_d;
`endif

  // Zero padding keeps every shift 0..15 inside the vector.
  assign concat = {5'd0, i_word, prev_word};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prev_word <= '0;
      o_word    <= '0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      prev_word <= i_word;
      o_word    <= concat[o_shift +: 10];
    end
  end

  assign is_token = (o_word == 10'h354) || (o_word == 10'h0ab) ||
                    (o_word == 10'h154) || (o_word == 10'h2ab);
  assign tok_next = (is_token && tok_q != TOK_MIN) ? tok_q + 1'b1 : tok_q;
  assign pass     = (tok_q >= TOK_MIN);

  always_comb begin
    // NOTE: every value written here gets a default first, so no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    tok_d        = tok_q;
    delay_d      = o_delay;
    shift_d      = o_shift;
    locked_d     = o_locked;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    restart      = i_restart;
`ifdef HDMIIN_ALIGN_TRACK_EN
    miss_d       = miss_q;
`endif
    case (state_q)
      SETTLE: begin
        tok_d = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        tok_d = tok_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // Strictly-greater comparison keeps the first run of maximal length.
        if (pass) begin
          if (run_len_q == '0) run_start_d = o_delay;
          run_len_d = run_len_q + 1'b1;
          if (run_len_d > best_len_q) begin
            best_start_d = run_start_d;
            best_len_d   = run_len_d;
          end
        end else begin
          run_len_d = '0;
        end
        if (o_delay != 5'd31) begin
          delay_d = o_delay + 1'b1;
          state_d = SETTLE;
        end else if (best_len_d >= EYE_MIN) begin
          delay_d = best_start_d + best_len_d[5:1];
          state_d = APPLY;
        end else begin
          delay_d      = '0;
          shift_d      = (o_shift == 4'd9) ? 4'd0 : o_shift + 1'b1;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          state_d      = SETTLE;
        end
      end
      APPLY: begin
        tok_d = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d    = '0;
          locked_d = 1'b1;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
`ifdef HDMIIN_ALIGN_TRACK_EN
        cnt_d = cnt_q + 1'b1;
        tok_d = tok_next;
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          tok_d = '0;
          if (tok_next < TOK_MIN) begin
            if (miss_q) restart = 1'b1;
            else        miss_d  = 1'b1;
          end else begin
            miss_d = 1'b0;
          end
        end
`endif
      end
      default: state_d = SETTLE;
    endcase

    // Restart keeps the word shift so recalibration resumes from the last alignment.
    if (restart) begin
      state_d      = SETTLE;
      cnt_d        = '0;
      tok_d        = '0;
      delay_d      = '0;
      locked_d     = 1'b0;
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
`ifdef HDMIIN_ALIGN_TRACK_EN
      miss_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= SETTLE;
      cnt_q        <= '0;
      tok_q        <= '0;
      o_delay      <= '0;
      o_shift      <= '0;
      o_locked     <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
`ifdef HDMIIN_ALIGN_TRACK_EN
      miss_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tok_q        <= tok_d;
      o_delay      <= delay_d;
      o_shift      <= shift_d;
      o_locked     <= locked_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
`ifdef HDMIIN_ALIGN_TRACK_EN
      miss_q       <= miss_d;
`endif
    end
  end

endmodule

// File: tb/tb_hdmiin_align_ctrl.sv
// Directed bench for hdmiin_align_ctrl with a small tap-eye model driving a token stream every 64 words.
`timescale 1ns/1ps

module tb_hdmiin_align_ctrl;

  // Reduced timing: tap = 4 settle + 64 measure + 1 eval = 69 cycles, sweep = 32 taps.
  localparam int TAP_CYC = 69;
  localparam int SWEEP   = 32 * TAP_CYC;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_restart = 1'b0;
  logic [9:0] i_word = '0;
  logic [4:0] o_delay;
  logic [3:0] o_shift;
  logic [9:0] o_word;
  logic       o_locked;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] pass_mask = '0;
  int          rot = 0;
  bit          tokens_on = 1'b1;
  bit          manual = 1'b0;
  int          phase = 0;
  logic [9:0]  gen_word;

  hdmiin_align_ctrl #(
    .LGDWELL(6), .MIN_TOKENS(1), .MIN_EYE(4), .LGSETTLE(2)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_restart(i_restart), .i_word(i_word),
    .o_delay(o_delay), .o_shift(o_shift), .o_word(o_word), .o_locked(o_locked)
  );

  always #5 i_clk = ~i_clk;

  // Channel model: passing taps see a 10'h354 token every 64 words, optionally
  // rotated by 3 bits (10'h2a0 then 10'h006); everything else is zero.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!manual) begin
        gen_word = '0;
        if (tokens_on && pass_mask[o_delay]) begin
          if (rot == 0) begin
            if (phase == 0) gen_word = 10'h354;
          end else begin
            if (phase == 0)      gen_word = 10'h2a0;
            else if (phase == 1) gen_word = 10'h006;
          end
        end
        i_word = gen_word;
      end
      phase = (phase + 1) % 64;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mask_range(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic apply_reset();
    @(negedge i_clk);
    i_reset   = 1'b1;
    i_restart = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic wait_lock(input int budget, output int cycles);
    cycles = 0;
    while (o_locked !== 1'b1 && cycles < budget) begin
      @(negedge i_clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    pass_mask = mask_range(10, 17);
    rot = 0;
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    n_checks++; if (o_delay !== 5'd0)  begin n_errors++; $display("FAIL reset_delay: got %0d expected 0", o_delay); end
    n_checks++; if (o_shift !== 4'd0)  begin n_errors++; $display("FAIL reset_shift: got %0d expected 0", o_shift); end
    n_checks++; if (o_word !== 10'd0)  begin n_errors++; $display("FAIL reset_word: got %h expected 000", o_word); end
    n_checks++; if (o_locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked: got %b expected 0", o_locked); end
    i_reset = 1'b0;
    repeat (TAP_CYC - 1) @(negedge i_clk);
    n_checks++; if (o_delay !== 5'd0) begin n_errors++; $display("FAIL first_tap_hold: got %0d expected 0", o_delay); end
    @(negedge i_clk);
    n_checks++; if (o_delay !== 5'd1) begin n_errors++; $display("FAIL first_tap_step: got %0d expected 1", o_delay); end
  endtask

  task automatic test_word_path();
    @(negedge i_clk);
    manual = 1'b1;
    i_word = 10'h3c5;
    @(negedge i_clk);
    i_word = 10'h12a;
    @(negedge i_clk);
    i_word = 10'h000;
    n_checks++; if (o_word !== 10'h3c5) begin n_errors++; $display("FAIL word_path_a: got %h expected 3c5", o_word); end
    @(negedge i_clk);
    n_checks++; if (o_word !== 10'h12a) begin n_errors++; $display("FAIL word_path_b: got %h expected 12a", o_word); end
    manual = 1'b0;
  endtask

  task automatic test_lock_shift0();
    int cyc;
    bit seen = 1'b0;
    pass_mask = mask_range(10, 17);
    rot = 0;
    tokens_on = 1'b1;
    apply_reset();
    wait_lock(3000, cyc);
    n_checks++; if (o_locked !== 1'b1) begin n_errors++; $display("FAIL s0_locked: got %b expected 1", o_locked); end
    n_checks++; if (cyc != SWEEP + 4)  begin n_errors++; $display("FAIL s0_lock_time: got %0d expected %0d", cyc, SWEEP + 4); end
    n_checks++; if (o_delay !== 5'd14) begin n_errors++; $display("FAIL s0_delay: got %0d expected 14", o_delay); end
    n_checks++; if (o_shift !== 4'd0)  begin n_errors++; $display("FAIL s0_shift: got %0d expected 0", o_shift); end
    for (int i = 0; i < 70; i++) begin
      @(negedge i_clk);
      if (o_word === 10'h354) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL s0_token_word: got none expected 354"); end
  endtask

  task automatic test_rotated();
    int cyc;
    bit seen = 1'b0;
    pass_mask = mask_range(5, 8);
    rot = 3;
    apply_reset();
    wait_lock(10000, cyc);
    n_checks++; if (o_locked !== 1'b1) begin n_errors++; $display("FAIL rot_locked: got %b expected 1", o_locked); end
    n_checks++; if (cyc != 4 * SWEEP + 4) begin n_errors++; $display("FAIL rot_lock_time: got %0d expected %0d", cyc, 4 * SWEEP + 4); end
    n_checks++; if (o_shift !== 4'd3)  begin n_errors++; $display("FAIL rot_shift: got %0d expected 3", o_shift); end
    n_checks++; if (o_delay !== 5'd7)  begin n_errors++; $display("FAIL rot_delay: got %0d expected 7", o_delay); end
    for (int i = 0; i < 70; i++) begin
      @(negedge i_clk);
      if (o_word === 10'h354) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL rot_token_word: got none expected 354"); end

    // Restart while locked keeps the shift and relocks in a single sweep.
    i_restart = 1'b1;
    @(negedge i_clk);
    i_restart = 1'b0;
    n_checks++; if (o_locked !== 1'b0) begin n_errors++; $display("FAIL rst_lk_locked: got %b expected 0", o_locked); end
    n_checks++; if (o_delay !== 5'd0)  begin n_errors++; $display("FAIL rst_lk_delay: got %0d expected 0", o_delay); end
    n_checks++; if (o_shift !== 4'd3)  begin n_errors++; $display("FAIL rst_lk_shift: got %0d expected 3", o_shift); end
    wait_lock(3000, cyc);
    n_checks++; if (cyc != SWEEP + 4)  begin n_errors++; $display("FAIL relock_time: got %0d expected %0d", cyc, SWEEP + 4); end
    n_checks++; if (o_delay !== 5'd7)  begin n_errors++; $display("FAIL relock_delay: got %0d expected 7", o_delay); end

    // Reset and restart together: reset wins, so the shift returns to 0.
    i_reset   = 1'b1;
    i_restart = 1'b1;
    @(negedge i_clk);
    i_reset   = 1'b0;
    i_restart = 1'b0;
    n_checks++; if (o_shift !== 4'd0)  begin n_errors++; $display("FAIL both_shift: got %0d expected 0", o_shift); end
    n_checks++; if (o_word !== 10'd0)  begin n_errors++; $display("FAIL both_word: got %h expected 000", o_word); end
    n_checks++; if (o_locked !== 1'b0) begin n_errors++; $display("FAIL both_locked: got %b expected 0", o_locked); end
  endtask

  task automatic test_first_run();
    int cyc;
    pass_mask = mask_range(2, 5) | mask_range(20, 23);
    rot = 0;
    apply_reset();
    wait_lock(3000, cyc);
    n_checks++; if (o_locked !== 1'b1) begin n_errors++; $display("FAIL two_run_locked: got %b expected 1", o_locked); end
    n_checks++; if (o_delay !== 5'd4)  begin n_errors++; $display("FAIL two_run_delay: got %0d expected 4", o_delay); end
    n_checks++; if (o_shift !== 4'd0)  begin n_errors++; $display("FAIL two_run_shift: got %0d expected 0", o_shift); end
  endtask

  task automatic test_narrow_eye();
    bit ever_locked = 1'b0;
    pass_mask = mask_range(10, 12);
    rot = 0;
    apply_reset();
    for (int k = 1; k <= 10; k++) begin
      for (int i = 0; i < SWEEP; i++) begin
        @(negedge i_clk);
        if (o_locked !== 1'b0) ever_locked = 1'b1;
      end
      n_checks++;
      if (o_shift !== 4'(k % 10)) begin
        n_errors++;
        $display("FAIL narrow_shift_%0d: got %0d expected %0d", k, o_shift, k % 10);
      end
    end
    n_checks++; if (o_delay !== 5'd0) begin n_errors++; $display("FAIL narrow_delay: got %0d expected 0", o_delay); end
    n_checks++; if (ever_locked) begin n_errors++; $display("FAIL narrow_never_locked: got lock expected none"); end
  endtask

  task automatic test_restart();
    pass_mask = mask_range(10, 17);
    rot = 0;
    apply_reset();
    repeat (12 * TAP_CYC + 32) @(negedge i_clk);
    n_checks++; if (o_delay !== 5'd12) begin n_errors++; $display("FAIL restart_pre_delay: got %0d expected 12", o_delay); end
    i_restart = 1'b1;
    @(negedge i_clk);
    i_restart = 1'b0;
    n_checks++; if (o_delay !== 5'd0)  begin n_errors++; $display("FAIL restart_delay: got %0d expected 0", o_delay); end
    n_checks++; if (o_locked !== 1'b0) begin n_errors++; $display("FAIL restart_locked: got %b expected 0", o_locked); end
    repeat (TAP_CYC - 1) @(negedge i_clk);
    n_checks++; if (o_delay !== 5'd0)  begin n_errors++; $display("FAIL restart_settle_hold: got %0d expected 0", o_delay); end
    @(negedge i_clk);
    n_checks++; if (o_delay !== 5'd1)  begin n_errors++; $display("FAIL restart_settle_step: got %0d expected 1", o_delay); end
  endtask

  task automatic test_tracking();
    int cyc;
    int c = 0;
    pass_mask = mask_range(10, 17);
    rot = 0;
    tokens_on = 1'b1;
    apply_reset();
    repeat (SWEEP) @(negedge i_clk);
    n_checks++; if (o_delay !== 5'd14) begin n_errors++; $display("FAIL track_apply_delay: got %0d expected 14", o_delay); end
    tokens_on = 1'b0;
    wait_lock(20, cyc);
    n_checks++; if (cyc != 4) begin n_errors++; $display("FAIL track_lock_time: got %0d expected 4", cyc); end
`ifdef HDMIIN_ALIGN_TRACK_EN
    while (o_locked === 1'b1 && c < 400) begin
      @(negedge i_clk);
      c++;
    end
    n_checks++; if (o_locked !== 1'b0) begin n_errors++; $display("FAIL track_drop: got %b expected 0", o_locked); end
    n_checks++; if (c != 128)          begin n_errors++; $display("FAIL track_drop_time: got %0d expected 128", c); end
    n_checks++; if (o_delay !== 5'd0)  begin n_errors++; $display("FAIL track_drop_delay: got %0d expected 0", o_delay); end
    repeat (TAP_CYC) @(negedge i_clk);
    n_checks++; if (o_delay !== 5'd1)  begin n_errors++; $display("FAIL track_recal: got %0d expected 1", o_delay); end
`else
    for (int i = 0; i < 400; i++) begin
      @(negedge i_clk);
      if (o_locked !== 1'b1) c++;
    end
    n_checks++; if (c != 0)            begin n_errors++; $display("FAIL hold_lock: got %0d unlocked cycles expected 0", c); end
    n_checks++; if (o_delay !== 5'd14) begin n_errors++; $display("FAIL hold_delay: got %0d expected 14", o_delay); end
`endif
    tokens_on = 1'b1;
  endtask

  initial begin
    test_reset();
    test_word_path();
    test_lock_shift0();
    test_rotated();
    test_first_run();
    test_narrow_eye();
    test_restart();
    test_tracking();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hdmiin_align_ctrl.md
HDMIIN_ALIGN_CTRL -- requirements
Module: hdmiin_align_ctrl

Interface
REQ-001 The block SHALL have parameter LGDWELL, default 12, giving log2 of the measurement window (cycles) per delay/shift setting.
REQ-002 The block SHALL have parameter MIN_TOKENS, default 8, giving the minimum control tokens per window for a setting to pass.
REQ-003 The block SHALL have parameter MIN_EYE, default 4, giving the minimum contiguous passing delay taps for an acceptable eye.
REQ-004 The block SHALL have parameter LGSETTLE, default 4, giving log2 of the cycles waited after any delay change.
REQ-005 The block SHALL have a single clock and a synchronous, active-high reset: i_clk  in  1  pixel clock; i_reset  in  1  synchronous active-high reset.
REQ-006 The block SHALL have i_restart  in  1  one-cycle pulse that forces a new calibration.
REQ-007 The block SHALL have i_word  in  10  raw deserialized TMDS word, one per i_clk.
REQ-008 The block SHALL have o_delay  out  5  IDELAY tap value driven to the deserializer.
REQ-009 The block SHALL have o_shift  out  4  current word-alignment shift, 0..9.
REQ-010 The block SHALL have o_word  out  10  aligned word.
REQ-011 The block SHALL have o_locked  out  1  high while calibrated.

Function
REQ-012 The block SHALL form concat = {i_word, previous i_word} (20 bits) and register o_word <= concat[o_shift +: 10]: one-cycle latency, valid in every state.
REQ-013 A token SHALL be counted when o_word equals 10'h354, 10'h0ab, 10'h154 or 10'h2ab; the counter saturates at MIN_TOKENS.
REQ-014 States SHALL be SETTLE, MEASURE, EVAL, APPLY, LOCKED.
REQ-015 SETTLE: wait 2^LGSETTLE cycles with o_delay stable, clear the token counter, then go to MEASURE.
REQ-016 MEASURE: count tokens for 2^LGDWELL cycles, then go to EVAL.
REQ-017 EVAL (one cycle): record pass = (count >= MIN_TOKENS) for the current tap; update run tracking (run start/length, best start/length; the first run of maximal length wins; runs do not wrap 31->0).
REQ-018 EVAL with o_delay<31: o_delay increments; go to SETTLE.
REQ-019 EVAL with o_delay==31 and best length >= MIN_EYE: o_delay <= best_start + floor(best_len/2); go to APPLY.
REQ-020 EVAL with o_delay==31 and no acceptable eye: o_delay <= 0; o_shift advances (9 wraps to 0); clear run state; go to SETTLE.
REQ-021 APPLY: wait 2^LGSETTLE cycles, then o_locked <= 1; go to LOCKED.
REQ-022 LOCKED: o_delay and o_shift SHALL hold.
REQ-023 i_restart in any state SHALL on the next cycle set o_locked=0, o_delay=0, clear run/best state and enter SETTLE; o_shift is retained.
REQ-024 i_restart coincident with i_reset: reset wins.

Reset
REQ-025 On i_reset: state=SETTLE, o_delay=0, o_shift=0, o_word=0, o_locked=0, all counters and run/best state cleared.
REQ-026 Calibration SHALL start automatically on the first cycle after reset deasserts.

Configuration
REQ-027 Macro HDMIIN_ALIGN_TRACK_EN defined: LOCKED keeps counting tokens in 2^LGDWELL windows; two consecutive windows below MIN_TOKENS SHALL drop o_locked and act as i_restart.
REQ-028 HDMIIN_ALIGN_TRACK_EN undefined: LOCKED holds until i_reset or i_restart, and no token monitoring logic is present.

Verification
REQ-029 The bench SHALL cover: reset, then a stream with 10'h354 every 64 words, aligned at shift 0, passing only taps 10..17 -> o_locked=1, o_delay=14, o_shift=0.
REQ-030 The bench SHALL cover: the same stream rotated by 3 bits, passing taps 5..8 -> shift 0 sweep fails, then o_shift=3, o_delay=7, locked.
REQ-031 The bench SHALL cover: passing runs 2..5 and 20..23 -> first run chosen, o_delay=4.
REQ-032 The bench SHALL cover: a run of 3 taps only (MIN_EYE=4) -> never locks; o_shift cycles 0..9 and wraps to 0.
REQ-033 The bench SHALL cover: i_restart pulsed mid-MEASURE at tap 12 -> next cycle o_delay=0, o_locked=0, state SETTLE.
REQ-034 The bench SHALL cover (HDMIIN_ALIGN_TRACK_EN): tokens removed after lock -> o_locked falls after exactly two failing windows and recalibration starts; without the macro, o_locked stays 1.
